target_controller: RTL and testbench



---
 rtl/target_controller.sv | 131 +++++++++++++
 tb/tb_target_controller.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/target_controller.sv
// target_controller: owns the snake-game food target.
// Compares the head position with the target on every HEAD_VALID strobe.
// A hit raises REACHED_TARGET for PULSE_CYCLES clocks and counts toward
// WIN_SCORE. A new target is then placed from a pair of free-running LFSRs.
// Ports:
//   CLK, RESET          clock, synchronous active-high reset
//   HEAD_X/HEAD_Y       snake head position, qualified by HEAD_VALID
//   TARGET_X/TARGET_Y   current target coordinate
//   REACHED_TARGET      hit pulse, PULSE_CYCLES clocks wide
//   TARGET_VALID        target placed and hittable
//   GAME_WON            sticky win flag, cleared only by RESET
module target_controller #(
  parameter int unsigned X_MAX        = 159,
  parameter int unsigned Y_MAX        = 119,
  parameter int unsigned INIT_X       = 80,
  parameter int unsigned INIT_Y       = 60,
  parameter logic [7:0]  SEED_X       = 8'hA5,
  parameter logic [6:0]  SEED_Y       = 7'h2B,
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned WIN_SCORE    = 10
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] HEAD_X,
  input  logic [6:0] HEAD_Y,
  input  logic       HEAD_VALID,
  output logic [7:0] TARGET_X,
  output logic [6:0] TARGET_Y,
  output logic       REACHED_TARGET,
  output logic       TARGET_VALID,
  output logic       GAME_WON
);

  localparam logic [7:0] X_MAX_C    = 8'(X_MAX);
  localparam logic [6:0] Y_MAX_C    = 7'(Y_MAX);
  localparam logic [7:0] INIT_X_C   = 8'(INIT_X);
  localparam logic [6:0] INIT_Y_C   = 7'(INIT_Y);
  localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYCLES - 1);
  localparam logic [3:0] WIN_C      = 4'(WIN_SCORE);

  localparam logic [1:0] ST_ARMED = 2'd0;
  localparam logic [1:0] ST_HIT   = 2'd1;
  localparam logic [1:0] ST_PLACE = 2'd2;
  localparam logic [1:0] ST_WON   = 2'd3;

  logic [1:0] state, state_nxt;
  logic [3:0] pulse_cnt, pulse_cnt_nxt;
  logic [3:0] hit_cnt, hit_cnt_nxt;
  logic [7:0] tgt_x_nxt;
  logic [6:0] tgt_y_nxt;
  logic [7:0] lfsr_x;
  logic [6:0] lfsr_y;
  logic       head_match_c;
  logic       cand_ok_c;

  // Free-running candidate generators; nonzero seeds keep them off zero.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      lfsr_x <= SEED_X;
      lfsr_y <= SEED_Y;
    end else begin
      lfsr_x <= {lfsr_x[6:0], lfsr_x[7] ^ lfsr_x[5] ^ lfsr_x[4] ^ lfsr_x[3]};
      lfsr_y <= {lfsr_y[5:0], lfsr_y[6] ^ lfsr_y[5]};
    end
  end

  assign head_match_c = (HEAD_X == TARGET_X) && (HEAD_Y == TARGET_Y);
  // Candidate must be on the grid and not under the snake head.
  assign cand_ok_c = (lfsr_x <= X_MAX_C) && (lfsr_y <= Y_MAX_C) &&
                     !((lfsr_x == HEAD_X) && (lfsr_y == HEAD_Y));

  // State and registered outputs; outputs are decoded from the next state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state          <= ST_ARMED;
      pulse_cnt      <= 4'd0;
      hit_cnt        <= 4'd0;
      TARGET_X       <= INIT_X_C;
      TARGET_Y       <= INIT_Y_C;
      REACHED_TARGET <= 1'b0;
      TARGET_VALID   <= 1'b1;
      GAME_WON       <= 1'b0;
    end else begin
      state          <= state_nxt;
      pulse_cnt      <= pulse_cnt_nxt;
      hit_cnt        <= hit_cnt_nxt;
      TARGET_X       <= tgt_x_nxt;
      TARGET_Y       <= tgt_y_nxt;
      REACHED_TARGET <= (state_nxt == ST_HIT);
      TARGET_VALID   <= (state_nxt == ST_ARMED);
      GAME_WON       <= (state_nxt == ST_WON);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt     = state;
    pulse_cnt_nxt = pulse_cnt;
    hit_cnt_nxt   = hit_cnt;
    tgt_x_nxt     = TARGET_X;
    tgt_y_nxt     = TARGET_Y;
    case (state)
      ST_ARMED: begin
        if (HEAD_VALID && head_match_c) begin
          state_nxt     = ST_HIT;
          pulse_cnt_nxt = PULSE_LAST;
        end
      end
      ST_HIT: begin
        // pulse_cnt counts remaining pulse cycles after the current one.
        if (pulse_cnt == 4'd0) begin
          hit_cnt_nxt = hit_cnt + 4'd1;
          state_nxt   = (hit_cnt_nxt == WIN_C) ? ST_WON : ST_PLACE;
        end else begin
          pulse_cnt_nxt = pulse_cnt - 4'd1;
        end
      end
      ST_PLACE: begin
        if (cand_ok_c) begin
          tgt_x_nxt = lfsr_x;
          tgt_y_nxt = lfsr_y;
          state_nxt = ST_ARMED;
        end
      end
      default: begin
        state_nxt = ST_WON;
      end
    endcase
  end

endmodule

// File: tb/tb_target_controller.sv
// Bench for target_controller: table of single-cycle head vectors, directed
// multi-cycle sequences and randomized hits checked against a model that
// predicts target placement from the LFSR sequences indexed by cycle number.
module tb_target_controller;

  localparam int unsigned X_MAX = 159;
  localparam int unsigned Y_MAX = 119;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] HEAD_X = 8'd0;
  logic [6:0] HEAD_Y = 7'd0;
  logic       HEAD_VALID = 1'b0;

  logic [7:0] tx [3];
  logic [6:0] ty [3];
  logic       rt [3];
  logic       tv [3];
  logic       gw [3];

  target_controller u_dut (
    .CLK(CLK), .RESET(RESET), .HEAD_X(HEAD_X), .HEAD_Y(HEAD_Y), .HEAD_VALID(HEAD_VALID),
    .TARGET_X(tx[0]), .TARGET_Y(ty[0]), .REACHED_TARGET(rt[0]),
    .TARGET_VALID(tv[0]), .GAME_WON(gw[0]));

  target_controller #(.WIN_SCORE(2)) u_win2 (
    .CLK(CLK), .RESET(RESET), .HEAD_X(HEAD_X), .HEAD_Y(HEAD_Y), .HEAD_VALID(HEAD_VALID),
    .TARGET_X(tx[1]), .TARGET_Y(ty[1]), .REACHED_TARGET(rt[1]),
    .TARGET_VALID(tv[1]), .GAME_WON(gw[1]));

  target_controller #(.PULSE_CYCLES(1)) u_p1 (
    .CLK(CLK), .RESET(RESET), .HEAD_X(HEAD_X), .HEAD_Y(HEAD_Y), .HEAD_VALID(HEAD_VALID),
    .TARGET_X(tx[2]), .TARGET_Y(ty[2]), .REACHED_TARGET(rt[2]),
    .TARGET_VALID(tv[2]), .GAME_WON(gw[2]));

  always #5 CLK = ~CLK;

  // Cycle index since the last reset edge; equals the LFSR step count.
  int cyc = 0;
  always @(posedge CLK) begin
    if (RESET) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Selected instance and its model parameters.
  logic [1:0] sel = 2'd0;
  int pulse_of [3] = '{2, 2, 1};
  int win_of   [3] = '{10, 2, 10};
  logic [7:0] tx_s;
  logic [6:0] ty_s;
  logic rt_s, tv_s, gw_s;
  always_comb begin
    tx_s = tx[sel];
    ty_s = ty[sel];
    rt_s = rt[sel];
    tv_s = tv[sel];
    gw_s = gw[sel];
  end

  // Full LFSR sequences from the seeds.
  logic [7:0] xs [255];
  logic [6:0] ys [127];

  int n_cmp = 0;
  int n_bad = 0;
  int hits = 0;
  int hits_total = 0;
  int pulses = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic bit cand_ok(input int t, input logic [7:0] hx, input logic [6:0] hy);
    logic [7:0] cx;
    logic [6:0] cy;
    cx = xs[t % 255];
    cy = ys[t % 127];
    return (int'(cx) <= X_MAX) && (int'(cy) <= Y_MAX) && !(cx == hx && cy == hy);
  endfunction

  // Assert reset for one edge; returns at the negedge of post-reset cycle 0.
  task automatic do_reset();
    RESET = 1'b1;
    HEAD_VALID = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    hits = 0;
  endtask

  // One hit on the selected instance, starting at a negedge in the armed state.
  // mode 0: head stays on old target; 1: head parked on first in-range
  // candidate; 2: random head during placement.
  task automatic do_hit(input int mode);
    int n, p, k;
    bit found, won;
    logic [7:0] ox, cx;
    logic [6:0] oy, cy;
    p = pulse_of[sel];
    chk("armed_tv", int'(tv_s), 1);
    ox = tx_s;
    oy = ty_s;
    HEAD_X = ox;
    HEAD_Y = oy;
    HEAD_VALID = 1'b1;
    n = cyc;
    @(negedge CLK);
    HEAD_VALID = 1'b0;
    hits++;
    hits_total++;
    won = (hits == win_of[sel]);
    if (mode == 1) begin
      found = 1'b0;
      for (int j = 0; j < 40000 && !found; j++) begin
        if (int'(xs[(n + p + 1 + j) % 255]) <= X_MAX && int'(ys[(n + p + 1 + j) % 127]) <= Y_MAX) begin
          HEAD_X = xs[(n + p + 1 + j) % 255];
          HEAD_Y = ys[(n + p + 1 + j) % 127];
          found = 1'b1;
        end
      end
    end else if (mode == 2) begin
      HEAD_X = 8'($urandom);
      HEAD_Y = 7'($urandom);
    end
    for (int i = 1; i <= p; i++) begin
      chk("pulse_hi", int'(rt_s), 1);
      chk("pulse_tv", int'(tv_s), 0);
      chk("pulse_tx_hold", int'(tx_s), int'(ox));
      if (i == 1 && rt_s) pulses++;
      HEAD_VALID = 1'($urandom_range(0, 1));
      @(negedge CLK);
    end
    HEAD_VALID = 1'b0;
    chk("pulse_end", int'(rt_s), 0);
    if (won) begin
      chk("won_flag", int'(gw_s), 1);
      chk("won_tv", int'(tv_s), 0);
      return;
    end
    chk("no_win", int'(gw_s), 0);
    found = 1'b0;
    k = n + p + 1;
    for (int j = 0; j < 40000 && !found; j++) begin
      if (cand_ok(n + p + 1 + j, HEAD_X, HEAD_Y)) begin
        k = n + p + 1 + j;
        found = 1'b1;
      end
    end
    chk("model_found", int'(found), 1);
    cx = xs[k % 255];
    cy = ys[k % 127];
    while (cyc <= k) begin
      chk("place_tv", int'(tv_s), 0);
      chk("place_rt", int'(rt_s), 0);
      chk("place_tx_hold", int'(tx_s), int'(ox));
      chk("place_ty_hold", int'(ty_s), int'(oy));
      @(negedge CLK);
    end
    chk("new_tx", int'(tx_s), int'(cx));
    chk("new_ty", int'(ty_s), int'(cy));
    chk("new_tv", int'(tv_s), 1);
    chk("range_x", int'(tx_s >= 8'd1 && int'(tx_s) <= X_MAX), 1);
    chk("range_y", int'(ty_s >= 7'd1 && int'(ty_s) <= Y_MAX), 1);
    chk("not_head", int'(!(tx_s == HEAD_X && ty_s == HEAD_Y)), 1);
  endtask

  typedef struct {
    logic [7:0] hx;
    logic [6:0] hy;
    logic       hv;
    logic       exp_rt;
  } vec_t;

  vec_t vecs [9];

  initial begin
    xs[0] = 8'hA5;
    for (int i = 1; i < 255; i++) xs[i] = {xs[i-1][6:0], ^(xs[i-1] & 8'hB8)};
    ys[0] = 7'h2B;
    for (int i = 1; i < 127; i++) ys[i] = {ys[i-1][5:0], ^(ys[i-1] & 7'h60)};

    vecs[0] = '{8'd80,  7'd60,  1'b1, 1'b1};
    vecs[1] = '{8'd80,  7'd60,  1'b0, 1'b0};
    vecs[2] = '{8'd80,  7'd61,  1'b1, 1'b0};
    vecs[3] = '{8'd81,  7'd60,  1'b1, 1'b0};
    vecs[4] = '{8'd79,  7'd60,  1'b1, 1'b0};
    vecs[5] = '{8'd80,  7'd59,  1'b1, 1'b0};
    vecs[6] = '{8'd0,   7'd0,   1'b1, 1'b0};
    vecs[7] = '{8'd208, 7'd60,  1'b1, 1'b0};
    vecs[8] = '{8'd80,  7'd124, 1'b1, 1'b0};

    @(negedge CLK);
    // 1: reset values
    sel = 2'd0;
    do_reset();
    chk("rst_tx", int'(tx_s), 80);
    chk("rst_ty", int'(ty_s), 60);
    chk("rst_tv", int'(tv_s), 1);
    chk("rst_rt", int'(rt_s), 0);
    chk("rst_gw", int'(gw_s), 0);

    // Table: single head vector from reset, response one cycle later.
    foreach (vecs[i]) begin
      do_reset();
      HEAD_X = vecs[i].hx;
      HEAD_Y = vecs[i].hy;
      HEAD_VALID = vecs[i].hv;
      @(negedge CLK);
      HEAD_VALID = 1'b0;
      chk("vec_rt", int'(rt_s), int'(vecs[i].exp_rt));
      chk("vec_tv", int'(tv_s), int'(!vecs[i].exp_rt));
      chk("vec_tx", int'(tx_s), 80);
      chk("vec_ty", int'(ty_s), 60);
    end

    // 2: hit at init target, head stays on it during placement
    do_reset();
    do_hit(0);
    chk("new_ne_init", int'(!(tx_s == 8'd80 && ty_s == 7'd60)), 1);

    // 3: matching head without strobe, then strobe off by one
    do_reset();
    HEAD_X = 8'd80;
    HEAD_Y = 7'd60;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      chk("nostrobe_rt", int'(rt_s), 0);
      chk("nostrobe_tv", int'(tv_s), 1);
    end
    HEAD_Y = 7'd61;
    HEAD_VALID = 1'b1;
    @(negedge CLK);
    HEAD_VALID = 1'b0;
    chk("offby1_rt", int'(rt_s), 0);
    chk("offby1_tx", int'(tx_s), 80);
    chk("offby1_ty", int'(ty_s), 60);

    // 4: WIN_SCORE=2 instance, two hits then sticky win
    sel = 2'd1;
    do_reset();
    do_hit(0);
    do_hit(0);
    begin
      logic [7:0] wx;
      logic [6:0] wy;
      wx = tx_s;
      wy = ty_s;
      for (int i = 0; i < 100; i++) begin
        HEAD_X = wx;
        HEAD_Y = wy;
        HEAD_VALID = 1'($urandom_range(0, 1));
        @(negedge CLK);
        chk("won_sticky", int'(gw_s), 1);
        chk("won_rt", int'(rt_s), 0);
        chk("won_tv", int'(tv_s), 0);
        chk("won_tx_hold", int'(tx_s), int'(wx));
      end
      HEAD_VALID = 1'b0;
    end

    // 5: reset on the first pulse cycle clears pulse, target and hit count
    do_reset();
    do_hit(0);
    HEAD_X = tx_s;
    HEAD_Y = ty_s;
    HEAD_VALID = 1'b1;
    @(negedge CLK);
    HEAD_VALID = 1'b0;
    chk("pre_rst_rt", int'(rt_s), 1);
    do_reset();
    chk("midpulse_rst_rt", int'(rt_s), 0);
    chk("midpulse_rst_tx", int'(tx_s), 80);
    chk("midpulse_rst_ty", int'(ty_s), 60);
    chk("midpulse_rst_tv", int'(tv_s), 1);
    chk("midpulse_rst_gw", int'(gw_s), 0);
    do_hit(0);
    chk("count_cleared", int'(gw_s), 0);
    do_hit(0);

    // 6: random hits on default and PULSE_CYCLES=1 instances
    pulses = 0;
    hits_total = 0;
    for (int s = 0; s < 2; s++) begin
      sel = (s == 0) ? 2'd0 : 2'd2;
      do_reset();
      for (int h = 0; h < 500; h++) begin
        int idle;
        idle = $urandom_range(0, 3);
        for (int i = 0; i < idle; i++) begin
          logic [7:0] hx;
          logic [6:0] hy;
          hx = 8'($urandom);
          hy = 7'($urandom);
          if (hx == tx_s && hy == ty_s) hx = hx ^ 8'h01;
          HEAD_X = hx;
          HEAD_Y = hy;
          HEAD_VALID = 1'($urandom_range(0, 1));
          @(negedge CLK);
          HEAD_VALID = 1'b0;
          chk("idle_rt", int'(rt_s), 0);
          chk("idle_tv", int'(tv_s), 1);
        end
        do_hit(($urandom_range(0, 1) == 0) ? 1 : 2);
        if (hits == win_of[sel]) do_reset();
      end
    end
    chk("pulse_count", pulses, hits_total);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
